// File: rtl/lram_port_ctrl.sv
// lram_port_ctrl: valid/ready request port to LRAM strobes, in-order read data via credit-limited response FIFO.
// Define LRAM_PORT_CTRL_CLEAR_EN to zero-fill every LRAM word after reset before accepting requests.
module lram_port_ctrl #(
   parameter int ADDR_W    = 14,
   parameter int DATA_W    = 32,
   parameter int RD_LAT    = 2,
   parameter int RSP_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_be,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                lram_ce,
   output logic                lram_we,
   output logic [ADDR_W-1:0]   lram_addr,
   output logic [DATA_W-1:0]   lram_din,
   output logic [DATA_W/8-1:0] lram_be,
   input  logic [DATA_W-1:0]   lram_dout,
   output logic                busy
);
   localparam int BE_W = DATA_W / 8;
   localparam int PW   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CW   = PW + 1;
   localparam int FW   = PW + 2;

   if (RD_LAT < 1 || RD_LAT > 2) begin : g_bad_lat
      $error("RD_LAT must be 1 or 2");
   end

   typedef enum logic [1:0] {S_RESET, S_CLEAR, S_RUN} state_t;

   state_t              state_q, state_d;
   logic                lram_ce_q, lram_ce_d, lram_we_q, lram_we_d;
   logic [ADDR_W-1:0]   lram_addr_q, lram_addr_d;
   logic [DATA_W-1:0]   lram_din_q, lram_din_d;
   logic [BE_W-1:0]     lram_be_q, lram_be_d;
   logic [RD_LAT-1:0]   rd_pipe_q, rd_pipe_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0]   mem_q [RSP_DEPTH];
   logic [FW-1:0]       in_flight;
   logic                lram_rd, push, pop, accept;
`ifdef LRAM_PORT_CTRL_CLEAR_EN
   logic [ADDR_W-1:0]   clr_q, clr_d;
`endif

   assign lram_ce   = lram_ce_q;
   assign lram_we   = lram_we_q;
   assign lram_addr = lram_addr_q;
   assign lram_din  = lram_din_q;
   assign lram_be   = lram_be_q;
   assign busy      = state_q != S_RUN;
   assign rsp_valid = cnt_q != '0;
   assign rsp_rdata = rsp_valid ? mem_q[rd_ptr_q] : '0;

   always_comb begin
      lram_rd     = lram_ce_q & ~lram_we_q;
      pop         = rsp_valid & rsp_ready;
      push        = rd_pipe_q[RD_LAT-1];
      // Credit covers every read already issued to the LRAM but not yet consumed.
      in_flight   = FW'(cnt_q) + FW'(lram_rd) + FW'($countones(rd_pipe_q)) - FW'(pop);
      req_ready   = (state_q == S_RUN) && (in_flight < FW'(RSP_DEPTH));
      accept      = req_valid & req_ready;
      lram_ce_d   = accept;
      lram_we_d   = accept & req_we;
      lram_addr_d = accept ? req_addr : lram_addr_q;
      lram_din_d  = accept ? req_wdata : lram_din_q;
      lram_be_d   = accept ? (req_we ? req_be : '0) : lram_be_q;
      rd_pipe_d   = RD_LAT'({rd_pipe_q, lram_rd});
      cnt_d       = cnt_q + CW'(push) - CW'(pop);
      wr_ptr_d    = wr_ptr_q + PW'(push);
      rd_ptr_d    = rd_ptr_q + PW'(pop);
      state_d     = state_q;
`ifdef LRAM_PORT_CTRL_CLEAR_EN
      clr_d       = clr_q;
      if (state_q == S_RESET) state_d = S_CLEAR;
      if (state_q == S_CLEAR) begin
         lram_ce_d   = 1'b1;
         lram_we_d   = 1'b1;
         lram_addr_d = clr_q;
         lram_din_d  = '0;
         lram_be_d   = '1;
         clr_d       = clr_q + 1'b1;
         state_d     = (&clr_q) ? S_RUN : S_CLEAR;
      end
`else
      if (state_q == S_RESET) state_d = S_RUN;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_RESET;
         lram_ce_q   <= 1'b0;
         lram_we_q   <= 1'b0;
         lram_addr_q <= '0;
         lram_din_q  <= '0;
         lram_be_q   <= '0;
         rd_pipe_q   <= '0;
         cnt_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
`ifdef LRAM_PORT_CTRL_CLEAR_EN
         clr_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         lram_ce_q   <= lram_ce_d;
         lram_we_q   <= lram_we_d;
         lram_addr_q <= lram_addr_d;
         lram_din_q  <= lram_din_d;
         lram_be_q   <= lram_be_d;
         rd_pipe_q   <= rd_pipe_d;
         cnt_q       <= cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
`ifdef LRAM_PORT_CTRL_CLEAR_EN
         clr_q       <= clr_d;
`endif
         if (push && !pop) assert (cnt_q < CW'(RSP_DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && push) mem_q[wr_ptr_q] <= lram_dout;
   end
endmodule

// File: doc/lram_port_ctrl.md
Name: lram_port_ctrl

Overview:
- Request-side controller directly upstream of one LRAM_CORE (16K x 32 LRAM block) on the LIFCL fabric.
- Converts a valid/ready request stream (read/write, byte enables) into the LRAM's single-port CE/WE/ADDR/DIN strobes.
- Tracks the fixed LRAM read latency and returns read data in order through a small response FIFO with backpressure.

Parameters:
- ADDR_W, 14, word address width (2^ADDR_W words, 16384 default).
- DATA_W, 32, data width; byte enables are DATA_W/8 wide.
- RD_LAT, 2, LRAM read latency in cycles, 1 or 2 (output register off/on); other values are illegal.
- RSP_DEPTH, 4, response FIFO depth, power of two, >= RD_LAT+1.

Ports:
- clk  in  1  single clock; LRAM and controller share it.
- rst_n  in  1  synchronous reset, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid&ready.
- req_we  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte enables (writes only).
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer accepts rsp_rdata.
- rsp_rdata  out  DATA_W  read data, in request order.
- lram_ce  out  1  LRAM chip enable.
- lram_we  out  1  LRAM write enable.
- lram_addr  out  ADDR_W  LRAM address.
- lram_din  out  DATA_W  LRAM write data.
- lram_be  out  DATA_W/8  LRAM byte write enables.
- lram_dout  in  DATA_W  LRAM read data.
- busy  out  1  high while not in RUN state.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, lram_ce=0, lram_we=0, lram_addr=0, lram_din=0, lram_be=0, busy=1. Reset also flushes the FIFO and the read pipeline.
- Reset mid-operation discards in-flight reads; no response is ever emitted for them.
- FSM states: RESET -> (CLEAR, macro only) -> RUN. RESET lasts exactly one cycle after rst_n deasserts. busy=0 only in RUN.
- LRAM strobes are registered. An accepted request drives lram_ce=1 (and lram_we=req_we, addr/din/be) on the next cycle. Otherwise lram_ce=0 and lram_we=0.
- Reads: lram_be is driven 0.
- Read tracking: a shift register of RD_LAT valid bits. lram_dout is captured into the FIFO exactly RD_LAT cycles after the lram_ce read cycle.
- Total read latency is RD_LAT+2 cycles from acceptance to rsp_valid when the FIFO is empty.
- Credit rule: in_flight = FIFO occupancy + pending pipeline reads.
  - In RUN, req_ready=1 iff in_flight < RSP_DEPTH, evaluated after counting a pop in the same cycle.
  - Writes consume no credit but share req_ready, for a single ordered port.
  - FIFO overflow is therefore impossible; an overflow is an assertion failure.
- Throughput: one request per cycle sustained while rsp_ready=1.
- Simultaneous FIFO push and pop: occupancy unchanged. Pointers wrap modulo RSP_DEPTH.
- rsp_valid/rsp_rdata stay stable while rsp_valid&!rsp_ready.
- Write followed by read to the same address returns the new data, because LRAM accesses are issued in order.
- Address beyond 2^ADDR_W cannot occur (width-limited).

Optional Feature:
- Macro LRAM_PORT_CTRL_CLEAR_EN.
- Defined: after RESET, state CLEAR writes zero to every word, address 0..2^ADDR_W-1 ascending, one per cycle, with lram_be all-ones.
  - req_ready=0 and busy=1 throughout.
  - Enters RUN the cycle after the last address is written.
  - Reset during CLEAR restarts the clear from address 0.
- Undefined: RESET goes directly to RUN; no clear counter is built.

Test Plan:
- Reset release, macro off, RD_LAT=2 -> busy=0 and req_ready=1 on the 2nd cycle after rst_n rises; all LRAM strobes 0 until the first request.
- Write 0xDEADBEEF to 0x0010 with be=0xF, then read 0x0010 -> rsp_rdata=0xDEADBEEF, rsp_valid exactly 4 cycles after read acceptance.
- Write 0x11223344, then write 0xAABBCCDD with be=0x3 to the same address, then read -> 0x1122CCDD.
- Hold rsp_ready=0 and issue 6 back-to-back reads -> exactly 4 accepted, req_ready=0 after that. Release rsp_ready -> remaining reads accepted, all 6 responses returned in order.
- Assert rst_n=0 with 2 reads in flight -> rsp_valid never asserts for them; FIFO empty after reset.
- Macro on, ADDR_W=4 -> 16 consecutive zero writes to addresses 0..15, busy=1 for 17 cycles; a subsequent read of any address returns 0.
